// File: rtl/lb_cnt_pkg.sv
// Shared types and helpers for the lb_updown_counter_n family.
// Build option: define LB_CNT_MATCH_EN to add the MVAL/MATCH compare port pair on the top.
package lb_cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Load values at or beyond the modulus land on the top of the range.
    // mod is one bit wider than d so that a full 2**32 modulus is representable.
    function automatic logic [MAX_WIDTH-1:0] clamp_load(
        input logic [MAX_WIDTH-1:0] d,
        input logic [MAX_WIDTH:0]   mod
    );
        logic [MAX_WIDTH-1:0] top;
        top = mod[MAX_WIDTH-1:0] - MAX_WIDTH'(1);
        if ({1'b0, d} < mod) begin
            return d;
        end
        return top;
    endfunction

endpackage

// File: rtl/lb_cnt_next.sv
// Next-state logic for lb_updown_counter_n: load clamp, up/down step with
// wrap or saturate at the range ends, terminal-count and overflow-event detection.
module lb_cnt_next
    import lb_cnt_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MOD_VAL = 64'd1 << WIDTH,
    parameter cnt_mode_e       MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             con,
    input  logic             ci,
    input  logic             sd,
    output logic [WIDTH-1:0] q_next,
    output logic             at_term,
    output logic             ovf_evt
);

    localparam logic [WIDTH-1:0]     MAX_Q   = WIDTH'(MOD_VAL - 64'd1);
    localparam logic [MAX_WIDTH:0]   MOD_EXT = MOD_VAL[MAX_WIDTH:0];

    logic [MAX_WIDTH-1:0] d_ext;
    logic [WIDTH-1:0]     q_load;
    logic [WIDTH-1:0]     q_step;

    assign d_ext   = MAX_WIDTH'(d);
    assign q_load  = WIDTH'(clamp_load(d_ext, MOD_EXT));
    assign at_term = (con == DIR_UP) ? (q == MAX_Q) : (q == '0);
    assign ovf_evt = ~sd & ci & at_term;

    // The range end is tested before stepping, so q+1 / q-1 never overflows.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        q_step = q;
        if (!at_term) begin
            q_step = (con == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
        end else if (MODE == CNT_WRAP) begin
            q_step = (con == DIR_UP) ? '0 : MAX_Q;
        end

        q_next = q;
        if (sd) begin
            q_next = q_load;
        end else if (ci) begin
            q_next = q_step;
        end
    end

endmodule

// File: rtl/lb_updown_counter_n.sv
// Loadable up/down counter with programmable modulus, wrap/saturate mode, sticky OVF and CI/CO cascade.
// Build option: LB_CNT_MATCH_EN adds MVAL input and registered MATCH output.
module lb_updown_counter_n
    import lb_cnt_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MOD_VAL   = 64'd1 << WIDTH,
    parameter int unsigned     SATURATE  = 0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             SP,
    input  logic             SD,
    input  logic             CON,
    input  logic             CI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             OVF
`ifdef LB_CNT_MATCH_EN
    ,
    input  logic [WIDTH-1:0] MVAL,
    output logic             MATCH
`endif
);

    localparam cnt_mode_e        MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_next;
    logic             at_term;
    logic             ovf_evt;
    logic             load;
    logic             count;

    lb_cnt_next #(
        .WIDTH   (WIDTH),
        .MOD_VAL (MOD_VAL),
        .MODE    (MODE)
    ) u_next (
        .q       (Q),
        .d       (D),
        .con     (CON),
        .ci      (CI),
        .sd      (SD),
        .q_next  (q_next),
        .at_term (at_term),
        .ovf_evt (ovf_evt)
    );

    assign load  = SP & SD;
    assign count = SP & ~SD & CI;

    // Carry-out is deliberately ungated by SP so a stalled stage still propagates terminal count.
    assign CO = CI & at_term;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            Q   <= RST_Q;
            OVF <= 1'b0;
        end else begin
            if (SP) begin
                Q <= q_next;
            end
            if (load) begin
                OVF <= 1'b0;
            end else if (count && ovf_evt) begin
                OVF <= 1'b1;
            end
        end
    end

`ifdef LB_CNT_MATCH_EN
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            MATCH <= 1'b0;
        end else begin
            MATCH <= (load || count) && (q_next == MVAL);
        end
    end
`endif

endmodule
